shift_periph: RTL and testbench

- Memory-mapped 16-bit logical barrel/serial shifter peripheral on the processor's simple I/O bus (cs/we/reg_sel).
- Software writes a control word (direction + amount), then an operand. Writing the operand starts a multi-cycle shift, one bit position per clock.
- Software polls a status register, then reads the result register.

---
 rtl/shift_periph_pkg.sv | 44 ++++
 rtl/shift_periph_core.sv | 89 ++++++++
 rtl/shift_periph.sv | 79 +++++++
 tb/tb_shift_periph.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_periph_pkg.sv
// Shared definitions for the shift peripheral: bus widths, register map,
// control/status bit positions and the core state encoding.
package shift_periph_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;
    // Counter must hold 16, one past the largest amount code.
    localparam int unsigned CNT_W  = AMT_W + 1;

    localparam logic [1:0] ADDR_CTRL    = 2'b00;
    localparam logic [1:0] ADDR_OPERAND = 2'b01;
    localparam logic [1:0] ADDR_RESULT  = 2'b10;
    localparam logic [1:0] ADDR_STATUS  = 2'b11;

    localparam int unsigned DIR_BIT  = 15;
    localparam int unsigned DONE_BIT = 0;
    localparam int unsigned BUSY_BIT = 1;

    // CTRL register layout; the middle bits are plain storage.
    typedef struct packed {
        logic                        dir;
        logic [DATA_W-AMT_W-2:0]     rsvd;
        logic [AMT_W-1:0]            amt;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } core_state_t;

    // Amount code 0..15 encodes a shift of 1..16 positions.
    function automatic logic [CNT_W-1:0] amt_to_count(input logic [AMT_W-1:0] amt);
        return CNT_W'(amt) + CNT_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] status_word(input logic busy, input logic done);
        logic [DATA_W-1:0] s;
        s           = '0;
        s[DONE_BIT] = done;
        s[BUSY_BIT] = busy;
        return s;
    endfunction

endpackage

// File: rtl/shift_periph_core.sv
// Serial shift engine: loads an operand on start, shifts one position per
// clock for 'count' clocks, then latches the result and raises done.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             load operand and (re)start, overrides any running op
//   operand, dir      value to shift and direction (1 right, 0 left)
//   count             number of positions, 1..16
//   result            last completed shift result
//   busy, done        operation in progress / last operation completed
module shift_periph_core
    import shift_periph_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] operand,
    input  logic              dir,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done
);

    core_state_t       r_state, w_state_nxt;
    logic [DATA_W-1:0] r_work,   w_work_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [DATA_W-1:0] r_result, w_result_nxt;
    logic              r_dir,    w_dir_nxt;
    logic              r_done,   w_done_nxt;
    logic [DATA_W-1:0] w_shifted;

    // Direction is captured at start so the op is independent of later CTRL state.
    assign w_shifted = r_dir ? (r_work >> 1) : (r_work << 1);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dir    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_dir    <= w_dir_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic; start has priority over a completion in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_dir_nxt    = r_dir;
        w_done_nxt   = r_done;

        if (start) begin
            w_state_nxt = ST_BUSY;
            w_work_nxt  = operand;
            w_cnt_nxt   = count;
            w_dir_nxt   = dir;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    w_work_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_result_nxt = w_shifted;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign busy   = (r_state == ST_BUSY);
    assign done   = r_done;

endmodule

// File: rtl/shift_periph.sv
// Memory-mapped 16-bit logical shifter peripheral. Holds the CTRL and
// OPERAND registers, decodes the simple cs/we/reg_sel bus and drives the
// combinational read path; the shifting itself lives in shift_periph_core.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   reg_sel      00 CTRL, 01 OPERAND, 10 RESULT, 11 STATUS
//   data_in      write data
//   cs, we       chip select, write enable (1 write / 0 read)
//   data_out     read data, zero unless a read is selected
module shift_periph
    import shift_periph_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        reg_sel,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cs,
    input  logic              we,
    output logic [DATA_W-1:0] data_out
);

    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_operand;
    logic              w_wr;
    logic              w_rd;
    logic              w_start;
    logic              w_ctrl_wr;
    logic [DATA_W-1:0] w_result;
    logic              w_busy;
    logic              w_done;

    assign w_wr      = cs && we;
    assign w_rd      = cs && !we;
    assign w_start   = w_wr && (reg_sel == ADDR_OPERAND);
    // CTRL is frozen while an operation is running.
    assign w_ctrl_wr = w_wr && (reg_sel == ADDR_CTRL) && !w_busy;

    // Software-visible CTRL and OPERAND registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_operand <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= ctrl_t'(data_in);
            end
            if (w_start) begin
                r_operand <= data_in;
            end
        end
    end

    shift_periph_core u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .operand (data_in),
        .dir     (r_ctrl.dir),
        .count   (amt_to_count(r_ctrl.amt)),
        .result  (w_result),
        .busy    (w_busy),
        .done    (w_done)
    );

    // Combinational read mux.
    always_comb begin
        data_out = '0;
        if (w_rd) begin
            case (reg_sel)
                ADDR_CTRL:    data_out = DATA_W'(r_ctrl);
                ADDR_OPERAND: data_out = r_operand;
                ADDR_RESULT:  data_out = w_result;
                ADDR_STATUS:  data_out = status_word(w_busy, w_done);
                default:      data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_periph.sv
// Bench for shift_periph: directed scenarios plus a randomized bus sequence,
// all compared against a transaction-level model of the register map.
`timescale 1ns/1ps
module tb_shift_periph;
    import shift_periph_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  reg_sel;
    logic [15:0] data_in;
    logic        cs;
    logic        we;
    logic [15:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [15:0] m_ctrl, m_op, m_res, m_fin;
    logic        m_done;
    int          m_rem;

    shift_periph dut (
        .clk      (clk),
        .reset    (reset),
        .reg_sel  (reg_sel),
        .data_in  (data_in),
        .cs       (cs),
        .we       (we),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Effect of one rising edge with the inputs currently on the bus.
    task automatic model_edge();
        logic        wr;
        logic        busy_old;
        logic [15:0] d;
        int          n;
        if (reset) begin
            m_ctrl = '0; m_op = '0; m_res = '0; m_fin = '0;
            m_done = 1'b0; m_rem = 0;
        end else begin
            wr       = cs && we;
            busy_old = (m_rem > 0);
            if (wr && reg_sel == ADDR_CTRL && !busy_old)
                m_ctrl = data_in;
            if (wr && reg_sel == ADDR_OPERAND) begin
                d      = data_in;
                n      = int'(m_ctrl[3:0]) + 1;
                m_op   = d;
                m_fin  = m_ctrl[15] ? (d >> n) : (d << n);
                m_rem  = n;
                m_done = 1'b0;
            end else if (busy_old) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_res  = m_fin;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] sel);
        if (!(cs && !we)) return 16'h0000;
        case (sel)
            ADDR_CTRL:    return m_ctrl;
            ADDR_OPERAND: return m_op;
            ADDR_RESULT:  return m_res;
            default:      return {14'd0, (m_rem > 0), m_done};
        endcase
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; reg_sel = sel; data_in = d;
        step();
        cs = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic chk_raw(input string tag, input logic [15:0] exp);
        n_tests++;
        assert (data_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
        end
    endtask

    // Read a register and compare with the model.
    task automatic chk(input string tag, input logic [1:0] sel);
        cs = 1'b1; we = 1'b0; reg_sel = sel;
        #1;
        chk_raw(tag, model_read(sel));
    endtask

    // Read a register and compare with a hand-derived constant.
    task automatic chk_const(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        cs = 1'b1; we = 1'b0; reg_sel = sel;
        #1;
        chk_raw(tag, exp);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; reg_sel = '0; data_in = '0;
        m_ctrl = '0; m_op = '0; m_res = '0; m_fin = '0; m_done = 1'b0; m_rem = 0;

        step(); step();
        reset = 1'b0;
        chk_const("rst_ctrl",    ADDR_CTRL,    16'h0000);
        chk_const("rst_operand", ADDR_OPERAND, 16'h0000);
        chk_const("rst_result",  ADDR_RESULT,  16'h0000);
        chk_const("rst_status",  ADDR_STATUS,  16'h0000);

        // Right by 2 of 0x0002.
        wr(ADDR_CTRL, 16'h8001);
        chk_const("ctrl_rb", ADDR_CTRL, 16'h8001);
        wr(ADDR_OPERAND, 16'h0002);
        chk_const("r2_busy0", ADDR_STATUS, 16'h0002);
        step();
        chk_const("r2_busy1", ADDR_STATUS, 16'h0002);
        step();
        chk_const("r2_done",  ADDR_STATUS, 16'h0001);
        chk_const("r2_result", ADDR_RESULT, 16'h0000);

        // Right by 1.
        wr(ADDR_CTRL, 16'h8000);
        wr(ADDR_OPERAND, 16'h0002);
        step();
        chk_const("r1_done",   ADDR_STATUS, 16'h0001);
        chk_const("r1_result", ADDR_RESULT, 16'h0001);

        // Left by 4, then left by 16.
        wr(ADDR_CTRL, 16'h0003);
        wr(ADDR_OPERAND, 16'h1234);
        for (int i = 0; i < 4; i++) step();
        chk_const("l4_result", ADDR_RESULT, 16'h2340);
        chk_const("l4_done",   ADDR_STATUS, 16'h0001);
        wr(ADDR_CTRL, 16'h000F);
        wr(ADDR_OPERAND, 16'hFFFF);
        for (int i = 0; i < 15; i++) step();
        chk_const("l16_busy",   ADDR_STATUS, 16'h0002);
        step();
        chk_const("l16_done",   ADDR_STATUS, 16'h0001);
        chk_const("l16_result", ADDR_RESULT, 16'h0000);

        // Restart a right-by-16 shift mid-flight.
        wr(ADDR_CTRL, 16'h800F);
        wr(ADDR_OPERAND, 16'hFFFF);
        for (int i = 0; i < 3; i++) step();
        wr(ADDR_OPERAND, 16'h0100);
        for (int i = 0; i < 15; i++) begin
            step();
            chk_const("restart_busy", ADDR_STATUS, 16'h0002);
        end
        step();
        chk_const("restart_done",   ADDR_STATUS, 16'h0001);
        chk_const("restart_result", ADDR_RESULT, 16'h0000);

        // Bus qualification: cs=0 writes are dropped, cs=0 reads return zero.
        cs = 1'b0; we = 1'b1; reg_sel = ADDR_CTRL; data_in = 16'h1234;
        step();
        cs = 1'b0; we = 1'b1; reg_sel = ADDR_OPERAND; data_in = 16'h5555;
        step();
        chk_const("nocs_ctrl",    ADDR_CTRL,    16'h800F);
        chk_const("nocs_operand", ADDR_OPERAND, 16'h0100);
        chk_const("nocs_status",  ADDR_STATUS,  16'h0001);
        cs = 1'b0; we = 1'b0; reg_sel = ADDR_CTRL;
        #1;
        chk_raw("nocs_read", 16'h0000);

        // CTRL write while busy is ignored.
        wr(ADDR_CTRL, 16'h0001);
        wr(ADDR_OPERAND, 16'hABCD);
        wr(ADDR_CTRL, 16'h8005);
        chk_const("busy_ctrl_wr", ADDR_CTRL, 16'h0001);
        step();
        chk_const("busy_ctrl_res", ADDR_RESULT, 16'hAF34);
        chk_const("busy_ctrl_st",  ADDR_STATUS, 16'h0001);

        // Reset during a shift.
        wr(ADDR_CTRL, 16'h800F);
        wr(ADDR_OPERAND, 16'hFFFF);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_const("midrst_status", ADDR_STATUS, 16'h0000);
        chk_const("midrst_result", ADDR_RESULT, 16'h0000);
        chk_const("midrst_ctrl",   ADDR_CTRL,   16'h0000);

        // Randomized bus traffic against the model.
        for (int it = 0; it < 400; it++) begin
            reset   = ($urandom_range(0, 59) == 0);
            cs      = ($urandom_range(0, 4) != 0);
            we      = ($urandom_range(0, 2) != 0);
            reg_sel = 2'($urandom_range(0, 3));
            data_in = 16'($urandom);
            step();
            reset = 1'b0;
            chk("rand_ctrl",    ADDR_CTRL);
            chk("rand_operand", ADDR_OPERAND);
            chk("rand_result",  ADDR_RESULT);
            chk("rand_status",  ADDR_STATUS);
            // Let some operations run to completion undisturbed.
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 17; k++) step();
                chk("rand_settle_result", ADDR_RESULT);
                chk("rand_settle_status", ADDR_STATUS);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
